cart_bus_ctrl: RTL

Cartridge-side bus controller that sits directly upstream of the Maria video/DMA chip. It translates each CPU or Maria DMA bus cycle into a cartridge ROM fetch on the external SDRAM port, or into an access to 16 KB of on-cart RAM. It applies SuperGame bank switching and returns the byte to the system data bus, with a stall flag while a fetch is in flight.

---
 rtl/cart_pkg.sv | 19 +
 rtl/cart_ram.sv | 24 ++
 rtl/cart_bus_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bus controller.
package cart_pkg;

    typedef enum logic {
        MAP_NONE = 1'b0,
        MAP_SG   = 1'b1
    } mapper_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROM_REQ = 2'd1,
        RAM_RD  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int          SG_BANK_BYTES = 16384;
    localparam logic [15:0] RAM_BASE      = 16'h4000;

endpackage

// File: rtl/cart_ram.sv
// Single-port on-cart RAM, synchronous read with one cycle of latency.
module cart_ram #(
    parameter int AW = 14
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [0:(1<<AW)-1];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cart_bus_ctrl.sv
// Cartridge bus controller: decodes bus cycles into SDRAM ROM fetches or
// on-cart RAM accesses, with SuperGame banking and a one-deep pending slot.
module cart_bus_ctrl
    import cart_pkg::*;
#(
    parameter int RAM_AW = 14,
    parameter int ROM_AW = 24
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic              bus_strobe,
    input  logic              cs_cart,
    input  logic              rw,
    input  logic [7:0]        wdata,
    input  mapper_t           mapper,
    input  logic              sg_ram,
    input  logic [9:0]        cart_kb,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              stall,
    output state_t            dbg_state_o,
    output logic              dbg_ovf_o,
    output logic [2:0]        dbg_bank_o
);

    state_t            state_q, state_d;
    logic              rom_req_q, rom_req_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              stall_q, stall_d;
    logic [2:0]        bank_q, bank_d;
    logic              ovf_q, ovf_d;
    logic              pend_v_q, pend_v_d;
    logic [15:0]       pend_addr_q, pend_addr_d;
    logic              pend_rw_q, pend_rw_d;
    logic [7:0]        pend_wdata_q, pend_wdata_d;

    logic              strobe;
    logic              req_v;
    logic [15:0]       req_addr;
    logic              req_rw;
    logic [7:0]        req_wdata;
    logic [19:0]       kb_bytes, none_base, none_lo, req_a20, rom_off;
    logic [5:0]        nb, nb_m1, bank_sel;
    logic              is_rom, is_ram, is_bank;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    // A waiting pending request takes priority over a fresh strobe in IDLE.
    assign strobe    = bus_strobe && cs_cart;
    assign req_v     = pend_v_q || strobe;
    assign req_addr  = pend_v_q ? pend_addr_q  : addr;
    assign req_rw    = pend_v_q ? pend_rw_q    : rw;
    assign req_wdata = pend_v_q ? pend_wdata_q : wdata;

    always_comb begin
        kb_bytes  = {cart_kb, 10'b0};
        none_base = 20'h10000 - kb_bytes;
        none_lo   = (none_base > 20'(RAM_BASE)) ? none_base : 20'(RAM_BASE);
        nb        = cart_kb[9:4];
        nb_m1     = nb - 6'd1;
        req_a20   = {4'b0, req_addr};
        is_rom    = 1'b0;
        is_ram    = 1'b0;
        is_bank   = 1'b0;
        bank_sel  = '0;
        rom_off   = '0;
        if (mapper == MAP_NONE) begin
            is_rom  = (req_a20 >= none_lo);
            rom_off = req_a20 - none_base;
        end else begin
            case (req_addr[15:14])
                2'b10: begin
                    is_rom   = 1'b1;
                    is_bank  = 1'b1;
                    bank_sel = {3'b0, bank_q};
                end
                2'b11: begin
                    is_rom   = 1'b1;
                    bank_sel = nb_m1;
                end
                2'b01: begin
                    if (sg_ram) begin
                        is_ram = 1'b1;
                    end else begin
                        is_rom   = 1'b1;
                        bank_sel = nb - 6'd2;
                    end
                end
                default: ;
            endcase
            rom_off = 20'(bank_sel) * 20'(SG_BANK_BYTES) + {6'b0, req_addr[13:0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        rom_req_d    = rom_req_q;
        rom_addr_d   = rom_addr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        stall_d      = stall_q;
        bank_d       = bank_q;
        ovf_d        = ovf_q;
        pend_v_d     = pend_v_q;
        pend_addr_d  = pend_addr_q;
        pend_rw_d    = pend_rw_q;
        pend_wdata_d = pend_wdata_q;
        ram_we       = 1'b0;

        case (state_q)
            IDLE: begin
                pend_v_d = 1'b0;
                if (req_v) begin
                    if (req_rw) begin
                        if (is_rom) begin
                            state_d    = ROM_REQ;
                            rom_req_d  = 1'b1;
                            rom_addr_d = ROM_AW'(rom_off);
                            stall_d    = 1'b1;
                        end else if (is_ram) begin
                            state_d = RAM_RD;
                            stall_d = 1'b1;
                        end else begin
                            dout_valid_d = 1'b1;
                        end
                    end else begin
                        if (is_bank) begin
                            bank_d = req_wdata[2:0] & nb_m1[2:0];
                        end
                        ram_we = is_ram;
                    end
                end
            end
            ROM_REQ: begin
                if (rom_ack) begin
                    state_d      = DONE;
                    rom_req_d    = 1'b0;
                    dout_d       = rom_data;
                    dout_valid_d = 1'b1;
                    stall_d      = 1'b0;
                end
            end
            RAM_RD: begin
                state_d      = DONE;
                dout_d       = ram_rdata;
                dout_valid_d = 1'b1;
                stall_d      = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // A strobe that cannot be serviced now lands in the slot; in IDLE the
        // slot is being drained this cycle, so refilling it is not an overflow.
        if (strobe && (state_q != IDLE || pend_v_q)) begin
            if (state_q != IDLE && pend_v_q) begin
                ovf_d = 1'b1;
            end
            pend_v_d     = 1'b1;
            pend_addr_d  = addr;
            pend_rw_d    = rw;
            pend_wdata_d = wdata;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            rom_req_q    <= 1'b0;
            rom_addr_q   <= '0;
            dout_q       <= 8'hFF;
            dout_valid_q <= 1'b0;
            stall_q      <= 1'b0;
            bank_q       <= '0;
            ovf_q        <= 1'b0;
            pend_v_q     <= 1'b0;
            pend_addr_q  <= '0;
            pend_rw_q    <= 1'b0;
            pend_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rom_req_q    <= rom_req_d;
            rom_addr_q   <= rom_addr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            stall_q      <= stall_d;
            bank_q       <= bank_d;
            ovf_q        <= ovf_d;
            pend_v_q     <= pend_v_d;
            pend_addr_q  <= pend_addr_d;
            pend_rw_q    <= pend_rw_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    cart_ram #(.AW(RAM_AW)) u_ram (
        .clk_i   (clk_sys),
        .we_i    (ram_we),
        .addr_i  (req_addr[RAM_AW-1:0]),
        .wdata_i (req_wdata),
        .rdata_o (ram_rdata)
    );

    assign rom_addr    = rom_addr_q;
    assign rom_req     = rom_req_q;
    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign stall       = stall_q;
    assign dbg_state_o = state_q;
    assign dbg_ovf_o   = ovf_q;
    assign dbg_bank_o  = bank_q;

endmodule
